// File: rtl/instr_encoder.sv
// Instruction encoder: range-checks structured instruction requests, packs them into
// 16-bit words and streams them into IMEM at consecutive addresses from a start pulse.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in RUN and never in a cycle that carries start.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LW    = 4'd0;
  localparam logic [3:0] OP_SW    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SRAI  = 4'd8;
  localparam logic [3:0] OP_SLLI  = 4'd9;
  localparam logic [3:0] OP_BEQZ  = 4'd10;
  localparam logic [3:0] OP_BNEQZ = 4'd11;

  localparam logic [1:0] EC_NONE  = 2'd0;
  localparam logic [1:0] EC_OPC   = 2'd1;
  localparam logic [1:0] EC_RANGE = 2'd2;
  localparam logic [1:0] EC_ZERO  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic signed [15:0]  w_imm;
  logic                w_imm_zero;
  logic                w_imm7_ok;
  logic                w_imm6_ok;
  logic                w_shamt_ok;
  logic                w_off9_ok;
  logic                w_base_ok;
  logic [15:0]         w_word;
  logic [1:0]          w_code;
  logic                w_fire;
  logic [ADDR_W:0]     w_count_inc;

  assign w_imm      = in_imm;
  assign w_imm_zero = (in_imm == 16'h0000);
  assign w_imm7_ok  = (w_imm >= -16'sd64)  && (w_imm <= 16'sd63);
  assign w_imm6_ok  = (w_imm >= -16'sd32)  && (w_imm <= 16'sd31);
  assign w_shamt_ok = (w_imm >= 16'sd1)    && (w_imm <= 16'sd15);
  assign w_off9_ok  = (w_imm >= -16'sd256) && (w_imm <= 16'sd255);
  // Only two base-register bits fit in the imm7 form.
  assign w_base_ok  = ~in_rs1[2];

  // Field packing and legality; zero-nzimm is reported ahead of a plain range error.
  always_comb begin
    w_word         = 16'h0000;
    w_code         = EC_NONE;
    w_word[15:12]  = in_opcode;
    case (in_opcode)
      OP_LW, OP_SW, OP_ANDI: begin
        w_word[11:9] = in_rd;
        w_word[8:7]  = in_rs1[1:0];
        w_word[6:0]  = in_imm[6:0];
        if (!w_imm7_ok || !w_base_ok) w_code = EC_RANGE;
      end
      OP_ADD, OP_AND, OP_OR, OP_XOR: begin
        w_word[11:9] = in_rd;
        w_word[8:6]  = in_rs1;
        w_word[5:3]  = in_rs2;
      end
      OP_ADDI: begin
        w_word[11:9] = in_rd;
        w_word[5:0]  = in_imm[5:0];
        if (w_imm_zero)      w_code = EC_ZERO;
        else if (!w_imm6_ok) w_code = EC_RANGE;
      end
      OP_SRAI, OP_SLLI: begin
        w_word[11:9] = in_rd;
        w_word[5:0]  = in_imm[5:0];
        if (w_imm_zero)       w_code = EC_ZERO;
        else if (!w_shamt_ok) w_code = EC_RANGE;
      end
      OP_BEQZ, OP_BNEQZ: begin
        w_word[11:9] = in_rd;
        w_word[8:0]  = in_imm[8:0];
        if (!w_off9_ok) w_code = EC_RANGE;
      end
      default: begin
        w_word = 16'h0000;
        w_code = EC_OPC;
      end
    endcase
  end

  assign in_ready    = (r_state == S_RUN) && !start;
  assign w_fire      = in_valid && in_ready;
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 16'h0000;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_state    <= S_RUN;
        r_count    <= '0;
        r_full     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= EC_NONE;
      end else if (w_fire) begin
        if (w_code != EC_NONE) begin
          r_state    <= S_ERR;
          r_err      <= 1'b1;
          r_err_code <= w_code;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_count[ADDR_W-1:0];
          r_wdata <= w_word;
          r_count <= w_count_inc;
          if (w_count_inc == DEPTH_C) begin
            r_state <= S_FULL;
            r_full  <= 1'b1;
          end
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = r_full;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written corner sequences and a
// randomized run checked every cycle against an arithmetic reference model.
module tb_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int W      = ADDR_W + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [3:0]        in_opcode = 4'd0;
  logic [2:0]        in_rd     = 3'd0;
  logic [2:0]        in_rs1    = 3'd0;
  logic [2:0]        in_rs2    = 3'd0;
  logic [15:0]       in_imm    = 16'h0000;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [1:0]        err_code;
  logic [1:0]        dbg_state;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err),
    .err_code(err_code), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_code(input int op, input int rs1, input int imm);
    if (op > 11) return 1;
    case (op)
      0, 1, 5:  return (imm < -64 || imm > 63 || rs1 > 3) ? 2 : 0;
      3:        return (imm == 0) ? 3 : ((imm < -32 || imm > 31) ? 2 : 0);
      8, 9:     return (imm == 0) ? 3 : ((imm < 1 || imm > 15) ? 2 : 0);
      10, 11:   return (imm < -256 || imm > 255) ? 2 : 0;
      default:  return 0;
    endcase
  endfunction

  function automatic int ref_word(input int op, input int rd, input int rs1,
                                  input int rs2, input int imm);
    int base;
    base = op * 4096 + rd * 512;
    case (op)
      0, 1, 5:  return base + (rs1 % 4) * 128 + (imm & 127);
      3, 8, 9:  return base + (imm & 63);
      10, 11:   return base + (imm & 511);
      default:  return base + rs1 * 64 + rs2 * 8;
    endcase
  endfunction

  // Model state after the most recent edge.
  bit          m_run  = 1'b0;
  bit          m_full = 1'b0;
  bit          m_err  = 1'b0;
  int          m_code = 0;
  int          m_cnt  = 0;
  bit          m_we   = 1'b0;
  logic [W-1:0] exp_q[$];

  // Scoreboard: compare outputs of the current cycle, then advance the model with
  // the inputs that the next rising edge will sample.
  initial begin
    forever begin
      logic [W-1:0] e;
      int imm_i, c;
      @(negedge clk);
      chk("ready", in_ready, m_run && !start);
      chk("we", imem_we, m_we);
      chk("count", count, m_cnt);
      chk("full", full, m_full);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      if (m_we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (imem_we) begin
          chk("addr", imem_addr, e[W-1:16]);
          chk("wdata", imem_wdata, e[15:0]);
        end
      end
      m_we = 1'b0;
      if (reset) begin
        m_run = 0; m_full = 0; m_err = 0; m_code = 0; m_cnt = 0;
        exp_q.delete();
      end else if (start) begin
        m_run = 1; m_full = 0; m_err = 0; m_code = 0; m_cnt = 0;
      end else if (in_valid && m_run) begin
        imm_i = int'($signed(in_imm));
        c = ref_code(int'(in_opcode), int'(in_rs1), imm_i);
        if (c != 0) begin
          m_err = 1; m_code = c; m_run = 0;
        end else begin
          e[W-1:16] = ADDR_W'(m_cnt);
          e[15:0]   = 16'(ref_word(int'(in_opcode), int'(in_rd), int'(in_rs1),
                                   int'(in_rs2), imm_i));
          exp_q.push_back(e);
          m_we = 1'b1;
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_full = 1; m_run = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] word;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[22];
  int   edge_imm[16] = '{-257, -256, -65, -64, -33, -32, 0, 1, 15, 16, 31, 32, 63, 64, 255, 256};

  initial begin
    vecs[0]  = '{4'd2,  3'd1, 3'd2, 3'd3, 16'h0000, 16'h2298, 2'd0};
    vecs[1]  = '{4'd0,  3'd2, 3'd1, 3'd7, 16'h0005, 16'h0485, 2'd0};
    vecs[2]  = '{4'd10, 3'd3, 3'd5, 3'd7, 16'hFFFE, 16'hA7FE, 2'd0};
    vecs[3]  = '{4'd3,  3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'd3};
    vecs[4]  = '{4'd5,  3'd1, 3'd0, 3'd0, 16'h0040, 16'h0000, 2'd2};
    vecs[5]  = '{4'd13, 3'd1, 3'd0, 3'd0, 16'h0001, 16'h0000, 2'd1};
    vecs[6]  = '{4'd1,  3'd5, 3'd3, 3'd7, 16'hFFC0, 16'h1BC0, 2'd0};
    vecs[7]  = '{4'd0,  3'd0, 3'd4, 3'd0, 16'h0000, 16'h0000, 2'd2};
    vecs[8]  = '{4'd3,  3'd7, 3'd0, 3'd7, 16'hFFE0, 16'h3E20, 2'd0};
    vecs[9]  = '{4'd8,  3'd1, 3'd6, 3'd7, 16'h000F, 16'h820F, 2'd0};
    vecs[10] = '{4'd9,  3'd1, 3'd0, 3'd0, 16'h0010, 16'h0000, 2'd2};
    vecs[11] = '{4'd9,  3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'd3};
    vecs[12] = '{4'd11, 3'd0, 3'd7, 3'd7, 16'h00FF, 16'hB0FF, 2'd0};
    vecs[13] = '{4'd10, 3'd0, 3'd0, 3'd0, 16'hFEFF, 16'h0000, 2'd2};
    vecs[14] = '{4'd4,  3'd4, 3'd5, 3'd6, 16'h1234, 16'h4970, 2'd0};
    vecs[15] = '{4'd7,  3'd2, 3'd1, 3'd7, 16'hFFFF, 16'h7478, 2'd0};
    vecs[16] = '{4'd5,  3'd6, 3'd2, 3'd7, 16'h003F, 16'h5D3F, 2'd0};
    vecs[17] = '{4'd10, 3'd1, 3'd0, 3'd0, 16'hFF00, 16'hA300, 2'd0};
    vecs[18] = '{4'd3,  3'd1, 3'd7, 3'd7, 16'h001F, 16'h321F, 2'd0};
    vecs[19] = '{4'd8,  3'd1, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 2'd2};
    vecs[20] = '{4'd12, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'd1};
    vecs[21] = '{4'd3,  3'd1, 3'd0, 3'd0, 16'h0020, 16'h0000, 2'd2};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_err", {err, err_code, full}, 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", in_ready, 1'b0);

    // Directed vector table: each entry is the first request of a fresh program
    for (int i = 0; i < 22; i++) begin
      pulse_start();
      set_req(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vecs[i].code == 2'd0) begin
        chk($sformatf("vec%0d_we", i), imem_we, 1'b1);
        chk($sformatf("vec%0d_addr", i), imem_addr, 0);
        chk($sformatf("vec%0d_wdata", i), imem_wdata, vecs[i].word);
        chk($sformatf("vec%0d_count", i), count, 1);
      end else begin
        chk($sformatf("vec%0d_we", i), imem_we, 1'b0);
        chk($sformatf("vec%0d_err", i), err, 1'b1);
        chk($sformatf("vec%0d_code", i), err_code, vecs[i].code);
        chk($sformatf("vec%0d_count", i), count, 0);
      end
    end

    // Second word of a program lands at address 1
    pulse_start();
    in_valid = 1'b1;
    set_req(4'd0, 3'd2, 3'd1, 3'd0, 16'h0005);
    tick();
    set_req(4'd10, 3'd3, 3'd0, 3'd0, 16'hFFFE);
    tick();
    in_valid = 1'b0;
    chk("seq2_addr", imem_addr, 1);
    chk("seq2_wdata", imem_wdata, 16'hA7FE);
    chk("seq2_count", count, 2);

    // Error is sticky: a later legal request is refused
    set_req(4'd3, 3'd1, 3'd0, 3'd0, 16'h0000);
    in_valid = 1'b1;
    tick();
    set_req(4'd2, 3'd1, 3'd2, 3'd3, 16'h0000);
    chk("err_ready", in_ready, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("err_hold_we", imem_we, 1'b0);
    chk("err_hold_code", err_code, 3);
    chk("err_hold_count", count, 2);
    pulse_start();
    chk("start_clr", {err, err_code, full}, 0);
    chk("start_count", count, 0);

    // Fill to DEPTH back to back, then hold valid against a full program
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(4'd2, 3'(i % 8), 3'd0, 3'd0, 16'h0000);
      tick();
      chk("fill_we", imem_we, 1'b1);
      chk("fill_addr", imem_addr, i);
      chk("fill_wdata", imem_wdata, 16'h2000 + 16'((i % 8) * 512));
    end
    chk("fill_full", full, 1'b1);
    chk("fill_ready", in_ready, 1'b0);
    chk("fill_count", count, DEPTH);
    tick();
    tick();
    chk("full_hold_we", imem_we, 1'b0);
    chk("full_hold_count", count, DEPTH);
    in_valid = 1'b0;

    // start and in_valid together: nothing accepted in the start cycle
    set_req(4'd2, 3'd1, 3'd2, 3'd3, 16'h0000);
    in_valid = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("startv_we", imem_we, 1'b0);
    chk("startv_count", count, 0);
    chk("startv_full", full, 1'b0);

    // Reset while a write is pending and a new request is offered
    in_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rstw_we", imem_we, 1'b0);
    chk("rstw_count", count, 0);
    chk("rstw_ready", in_ready, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Randomized run
    pulse_start();
    for (int n = 0; n < 4000; n++) begin
      int imm_i;
      case ($urandom_range(0, 3))
        0:       imm_i = int'($urandom_range(0, 16)) - 8;
        1:       imm_i = edge_imm[$urandom_range(0, 15)];
        2:       imm_i = int'($urandom);
        default: imm_i = int'($urandom_range(0, 600)) - 300;
      endcase
      set_req(($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)),
              3'($urandom_range(0, 7)),
              ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 16'(imm_i));
      in_valid = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0; reset = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
